btn_event_sched: RTL and testbench
==================================

# btn_event_sched

Multi-button event scheduler for the switch front end. Samples N raw push-button inputs on a shared slow sampling tick, detects press edges per button, queues one pending event per button, and hands events one at a time to a single consumer via a valid/ready handshake under round-robin arbitration. Sits between board button pins and any control logic that consumes button commands; replaces per-button debounce instances with one shared tick generator.

## Interface
- `BIT_SIZE`, 20: width of the tick counter; the sampling tick period is 2^BIT_SIZE clk cycles.
- `N_BTN`, 4: number of buttons, 2..16.
- `ID_W`, 2: width of `o_id`; N_BTN <= 2^ID_W is required.
- `clk` in 1: system clock.
- `i_sclr` in 1: asynchronous, active-high reset.
- `i_btn` in N_BTN: raw button levels, 1 = pressed; asynchronous to clk.
- `i_ready` in 1: consumer accepts the offered event.
- `i_ovf_clr` in 1: clears all `o_ovf` bits.
- `o_valid` out 1: event offered.
- `o_id` out ID_W: index of the button for the offered event.
- `o_tick` out 1: one-cycle sampling tick, for observation.
- `o_ovf` out N_BTN: sticky per-button overflow flags.

## Operation
- **Tick counter**
  - BIT_SIZE-bit counter, increments every clk and wraps.
  - `o_tick` = 1 exactly in the cycle where the count is 2^BIT_SIZE-1.
- **Sampling**
  - Each button has two stages, s1 and s2.
  - On the clk edge ending a tick cycle: s1 <= i_btn[i], s2 <= s1. No update occurs outside tick cycles.
- **Press detect**
  - In a tick cycle where the current values are s1=1 and s2=0, a press is detected for button i.
  - A level held high produces exactly one event.
  - A glitch shorter than one tick period is either missed or yields one event; it never yields two.
- **Pending**
  - One bit per button. Set on press detect; cleared when that button's event is accepted.
  - Set and clear in the same cycle: the set wins. Pending stays 1 and no overflow is flagged.
  - Press detect while pending is already 1 and not being cleared: the new event is dropped and `o_ovf[i]` is set.
- **Overflow flags**
  - `o_ovf` bits are sticky. `i_ovf_clr` clears all of them.
  - If a set and `i_ovf_clr` occur in the same cycle, the set wins.
- **FSM**
  - IDLE:
    - If any pending bit is set, select the first pending index at or after `ptr`, searching cyclically.
    - Register that index into `o_id`, assert `o_valid`, go to OFFER.
    - Otherwise stay in IDLE.
  - OFFER:
    - `o_valid` = 1; `o_id` is held stable.
    - If `i_ready` = 1: clear pending[o_id], set ptr <= (o_id+1) mod N_BTN, deassert `o_valid`, go to IDLE.
    - Otherwise stay in OFFER. There is no timeout.
  - The offered event cannot be withdrawn. New presses on other buttons do not change `o_id`.
- **Throughput:** at most one event every 2 cycles.
- **Reset (async assert, any time):**
  - counter 0, s1/s2 0, pending 0, `o_ovf` 0, ptr 0, state IDLE, `o_valid` 0, `o_id` 0, `o_tick` 0.
  - Events in flight are discarded.
  - After reset release, a button already held high produces one event, at the second tick after release.

## Timing
- `o_tick` is high in cycles T, T+2^BIT_SIZE, and so on, where T = 2^BIT_SIZE-1 cycles after reset release.
- Button goes high before tick cycle c0:
  - s1 = 1 after c0.
  - Press is detected in the next tick cycle c1.
  - Pending is high in c1+1.
  - `o_valid` is high from c1+2.
- Handshake completes on the edge where `o_valid` & `i_ready` = 1.
- `o_valid` is low in the following cycle. The next event is offered no earlier than 2 cycles after acceptance.
- `i_ready` is ignored while `o_valid` = 0.
- All outputs are registered, except `o_tick`, which is a decode of the counter.

## Test plan
Test configuration: BIT_SIZE=2 (tick every 4 clk), N_BTN=4, ID_W=2.

- **Single press:** reset, hold i_btn=4'b0010 for 20 cycles, `i_ready`=1 → exactly one handshake with `o_id`=1, `o_valid` high 2 cycles after the second tick, `o_ovf`=0.
- **Round robin:** i_btn=4'b1011 together, then release; `i_ready`=1 → `o_id` sequence 0,1,3. Then presses on 0 and 3 → order 3 before 0 wrapped? No: ptr=0 after 3 → 0,3.
- **Backpressure:** press button 2, `i_ready`=0 for 30 cycles → `o_valid` stays 1 and `o_id`=2 stable; meanwhile press button 0 → `o_id` does not change; raise `i_ready` → ids 2 then 0.
- **Overflow:** `i_ready`=0, press button 1 twice (release 8 cycles between) → `o_ovf`=4'b0010 and only one event for id 1 after ready; pulse `i_ovf_clr` → `o_ovf`=0.
- **Glitch:** a 1-cycle pulse on i_btn[3] not coincident with a tick → no event. A pulse aligned to a tick → at most one event.
- **Reset mid-operation:** assert `i_sclr` while `o_valid`=1 → all outputs 0 immediately (asynchronously). Pending is lost. With button 0 still held after release → one event, `o_id`=0.

Source files
------------

// File: rtl/btn_event_sched.sv
// btn_event_sched: shared-tick button sampler with per-button pending events and a round-robin valid/ready hand-off
module btn_event_sched #(
  parameter int BIT_SIZE = 20,
  parameter int N_BTN    = 4,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic [N_BTN-1:0] i_btn,
  input  logic             i_ready,
  input  logic             i_ovf_clr,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id,
  output logic             o_tick,
  output logic [N_BTN-1:0] o_ovf
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t              state_q, state_d;
  logic [BIT_SIZE-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]    s1_q, s1_d, s2_q, s2_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [N_BTN-1:0]    press, clr;
  logic [ID_W-1:0]     id_q, id_d, ptr_q, ptr_d, sel, idx;
  logic                valid_q, valid_d, found;
  assign o_tick  = &cnt_q;
  assign o_valid = valid_q;
  assign o_id    = id_q;
  assign o_ovf   = ovf_q;
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    s1_d   = o_tick ? i_btn : s1_q;
    s2_d   = o_tick ? s1_q : s2_q;
    press  = o_tick ? (s1_q & ~s2_q) : '0;
    clr    = (state_q == OFFER && i_ready) ? (N_BTN'(1) << id_q) : '0;
    pend_d = (pend_q & ~clr) | press;
    // a press colliding with an event that is still pending (and not leaving now) is lost
    ovf_d  = (i_ovf_clr ? '0 : ovf_q) | (press & pend_q & ~clr);
    found  = 1'b0;
    sel    = '0;
    idx    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_BTN);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE && found) begin
      state_d = OFFER;
      valid_d = 1'b1;
      id_d    = sel;
    end else if (state_q == OFFER && i_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ptr_d   = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_btn_event_sched.sv
// tb_btn_event_sched: directed checks of btn_event_sched with a 4-cycle sampling tick
module tb_btn_event_sched;
  logic       clk = 1'b0;
  logic       i_sclr, i_ready, i_ovf_clr, o_valid, o_tick;
  logic [3:0] i_btn, o_ovf;
  logic [1:0] o_id;
  logic [31:0] seq;
  int tests = 0, fails = 0;

  btn_event_sched #(.BIT_SIZE(2), .N_BTN(4), .ID_W(2)) dut (
    .clk(clk), .i_sclr(i_sclr), .i_btn(i_btn), .i_ready(i_ready), .i_ovf_clr(i_ovf_clr),
    .o_valid(o_valid), .o_id(o_id), .o_tick(o_tick), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // each accepted event appends nibble {1'b1, id} to seq
  task automatic run_count(input int n);
    logic hs;
    logic [1:0] id;
    for (int i = 0; i < n; i++) begin
      hs = o_valid & i_ready;
      id = o_id;
      step(1);
      if (hs) seq = (seq << 4) | {28'd0, 2'b10, id};
    end
  endtask

  task automatic do_reset();
    i_sclr = 1'b1;
    step(2);
    i_sclr = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!o_tick && n < 8) begin
      step(1);
      n++;
    end
    chk("tick_seen", {31'd0, o_tick}, 32'd1);
  endtask

  initial begin
    i_sclr = 1'b0; i_btn = '0; i_ready = 1'b0; i_ovf_clr = 1'b0; seq = '0;
    #2 i_sclr = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_id",    {30'd0, o_id},    32'd0);
    chk("rst_ovf",   {28'd0, o_ovf},   32'd0);
    chk("rst_tick",  {31'd0, o_tick},  32'd0);
    step(2);
    i_sclr = 1'b0;
    // single press: held from release, tick after edges 3 and 7, offer after edge 9
    i_btn = 4'b0010; i_ready = 1'b1;
    step(2);
    chk("sp_tick_lo", {31'd0, o_tick}, 32'd0);
    step(1);
    chk("sp_tick_hi", {31'd0, o_tick}, 32'd1);
    step(5);
    chk("sp_valid_early", {31'd0, o_valid}, 32'd0);
    step(1);
    chk("sp_valid", {31'd0, o_valid}, 32'd1);
    chk("sp_id",    {30'd0, o_id},    32'd1);
    seq = '0;
    run_count(11);
    i_btn = '0;
    run_count(10);
    chk("sp_seq", seq, 32'h9);
    chk("sp_ovf", {28'd0, o_ovf}, 32'd0);
    // round robin
    do_reset();
    seq = '0; i_btn = 4'b1011;
    run_count(12);
    i_btn = '0;
    run_count(12);
    chk("rr_seq1", seq, 32'h89B);
    seq = '0; i_btn = 4'b1001;
    run_count(12);
    i_btn = '0;
    run_count(12);
    chk("rr_seq2", seq, 32'h8B);
    // backpressure
    i_ready = 1'b0; i_btn = 4'b0100;
    run_count(12);
    chk("bp_valid1", {31'd0, o_valid}, 32'd1);
    chk("bp_id1",    {30'd0, o_id},    32'd2);
    i_btn = 4'b0001;
    run_count(18);
    chk("bp_valid2", {31'd0, o_valid}, 32'd1);
    chk("bp_id2",    {30'd0, o_id},    32'd2);
    seq = '0; i_btn = '0; i_ready = 1'b1;
    run_count(12);
    chk("bp_seq", seq, 32'hA8);
    chk("bp_ovf", {28'd0, o_ovf}, 32'd0);
    // overflow
    i_ready = 1'b0; i_btn = 4'b0010;
    run_count(12);
    i_btn = '0;
    run_count(12);
    i_btn = 4'b0010;
    run_count(12);
    i_btn = '0;
    run_count(4);
    chk("ov_ovf",   {28'd0, o_ovf},   32'h2);
    chk("ov_valid", {31'd0, o_valid}, 32'd1);
    chk("ov_id",    {30'd0, o_id},    32'd1);
    seq = '0; i_ready = 1'b1;
    run_count(12);
    chk("ov_seq", seq, 32'h9);
    chk("ov_sticky", {28'd0, o_ovf}, 32'h2);
    i_ovf_clr = 1'b1;
    step(1);
    i_ovf_clr = 1'b0;
    chk("ov_clr", {28'd0, o_ovf}, 32'd0);
    // glitch between ticks is never sampled
    wait_tick();
    step(1);
    i_btn = 4'b1000;
    step(1);
    i_btn = '0;
    seq = '0;
    run_count(16);
    chk("gl_off_seq", seq, 32'd0);
    // glitch covering a tick-ending edge is sampled once
    wait_tick();
    i_btn = 4'b1000;
    step(1);
    i_btn = '0;
    seq = '0;
    run_count(16);
    chk("gl_on_seq", seq, 32'hB);
    // reset while an event is offered
    i_ready = 1'b0; i_btn = 4'b0100;
    run_count(12);
    chk("mr_valid_pre", {31'd0, o_valid}, 32'd1);
    chk("mr_id_pre",    {30'd0, o_id},    32'd2);
    i_btn = 4'b0101;
    step(3);
    #2 i_sclr = 1'b1;
    #1;
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_id",    {30'd0, o_id},    32'd0);
    chk("mr_ovf",   {28'd0, o_ovf},   32'd0);
    chk("mr_tick",  {31'd0, o_tick},  32'd0);
    i_btn = 4'b0001;
    step(2);
    i_sclr = 1'b0; i_ready = 1'b1; seq = '0;
    run_count(16);
    i_btn = '0;
    run_count(8);
    chk("mr_seq", seq, 32'h8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
